edge_event_counter: RTL
=======================

// Module: edge_event_counter
// PURPOSE
//  Consumes a raw asynchronous level (switch/button or gate output) and produces a clean
//  one-cycle pulse per debounced rising edge, plus a running event count.
//  The pulse is the registered form of (~previous & current) on the debounced level.
//  It is the sequential stage downstream of the combinational gate exercises.
//  It converts their level outputs into countable events for later counter/display blocks.
// PARAMETERS
//  WIDTH     8  count register width in bits (1..16)
//  DEBOUNCE  3  consecutive stable cycles required to accept a level change (1..255)
//  SATURATE  1  1: count sticks at 2^WIDTH-1; 0: count wraps to 0
// PORTS
//  clk          in   1      single clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  in_sig       in   1      raw input, asynchronous to clk, may bounce
//  enable       in   1      1: accepted edges increment count; 0: count holds
//  clear        in   1      synchronous clear of count and overflow
//  level        out  1      debounced level
//  pulse        out  1      one-cycle high per accepted rising edge
//  count        out  WIDTH  accepted rising edges since reset/clear
//  overflow     out  1      sticky; set when an edge arrives with count at 2^WIDTH-1
// BEHAVIOUR
//  Reset: reset_n=0 forces all flops to 0 immediately, independent of clk.
//   level=0, pulse=0, count=0, overflow=0, FSM=LOW, stability counter=0.
//  Sync: 2-flop synchronizer on in_sig producing s. Only s feeds the FSM.
//  FSM (stability counter cnt, 8 bits):
//   LOW:    s=1 -> CHK_HI, cnt=1; else stay.
//   CHK_HI: s=0 -> LOW, cnt=0 (glitch rejected).
//           s=1 and cnt==DEBOUNCE-1 -> HIGH, level<=1, pulse<=1.
//           s=1 otherwise -> cnt++.
//   HIGH:   s=0 -> CHK_LO, cnt=1; else stay.
//   CHK_LO: s=1 -> HIGH, cnt=0.
//           s=0 and cnt==DEBOUNCE-1 -> LOW, level<=0 (no pulse).
//           s=0 otherwise -> cnt++.
//   DEBOUNCE=1: transition happens on the first edge on which s differs from level.
//  Latency: in_sig rises and stays high before clk edge 0.
//   s is high after edge 1. level and pulse rise after edge 1+DEBOUNCE.
//   Example: DEBOUNCE=3 gives high after edge 4. pulse lasts exactly one cycle.
//   A level held high indefinitely produces one pulse only.
//  Count: updated on the same edge that registers pulse=1, if enable=1.
//   Below max: count+1.
//   At max, SATURATE=1: count holds, overflow<=1.
//   At max, SATURATE=0: count<=0, overflow<=1.
//   enable=0: edges still generate pulse and level; count and overflow hold.
//  clear=1: count<=0, overflow<=0 on that edge, overriding a simultaneous increment.
//   clear does not affect FSM, level or pulse.
//  Reset mid-debounce: in-progress check is discarded.
//   A level still high after release needs 2+DEBOUNCE edges to produce a pulse.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include edge_defs.vh: FSM state encodings ST_LOW=2'd0, ST_CHK_HI=2'd1,
//   ST_HIGH=2'd2, ST_CHK_LO=2'd3; default WIDTH/DEBOUNCE values.
//  Sub-module sig_debounce (DEBOUNCE): synchronizer + FSM, outputs level and rise.
//  Top edge_event_counter instantiates sig_debounce and holds count/overflow logic.
// TESTING (WIDTH=8, DEBOUNCE=3 unless stated)
//  1 Reset: reset_n=0 mid-cycle with in_sig=1 -> all outputs 0 immediately.
//    After release, pulse on edge 5.
//  2 Clean edge: in_sig 0->1 held 10 cycles -> exactly one pulse, 4 edges after rise.
//    count 0->1, level=1. Then in_sig->0 -> level=0 after 4 edges, no pulse.
//  3 Glitch: in_sig high 2 cycles, then low -> no pulse, count=0, level=0.
//    Bounce 1-0-1-1-1 -> one pulse only.
//  4 Saturate: preload 255 accepted edges, 1 more edge -> count=255, overflow=1.
//    SATURATE=0 -> count=0, overflow=1.
//  5 Enable/clear: enable=0, 3 edges -> 3 pulses, count holds.
//    clear asserted on the same cycle as a pulse -> count=0, overflow=0.
//  6 Random stimulus vs reference model of the FSM, 10k cycles -> zero mismatches.

Source files
------------

// File: rtl/edge_event_counter_pkg.sv
// Shared definitions for the edge event counter: debounce FSM encoding and defaults.
package edge_event_counter_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEBOUNCE = 3;

    // Stability count at which a pending level change is accepted.
    function automatic logic [7:0] stable_target(input int debounce);
        return 8'(debounce - 1);
    endfunction

endpackage

// File: rtl/edge_event_counter_debounce.sv
// Synchronizer plus debounce FSM; emits the debounced level and a
// combinational rise flag that is high on the edge accepting a rising change.
module sig_debounce
    import edge_event_counter_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_sig,
    output logic level,
    output logic rise
);

    localparam logic [7:0] LAST = stable_target(DEBOUNCE);

    logic       sync_meta;
    logic       s;
    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       level_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
        end else begin
            sync_meta <= in_sig;
            s         <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOW;
            cnt   <= 8'd0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_LOW: begin
                if (s) begin
                    // With a one-cycle debounce the first differing sample is accepted.
                    if (DEBOUNCE == 1) begin
                        state_next = ST_HIGH;
                        cnt_next   = 8'd0;
                    end else begin
                        state_next = ST_CHK_HI;
                        cnt_next   = 8'd1;
                    end
                end
            end
            ST_CHK_HI: begin
                if (!s) begin
                    state_next = ST_LOW;
                    cnt_next   = 8'd0;
                end else if (cnt == LAST) begin
                    state_next = ST_HIGH;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (DEBOUNCE == 1) begin
                        state_next = ST_LOW;
                        cnt_next   = 8'd0;
                    end else begin
                        state_next = ST_CHK_LO;
                        cnt_next   = 8'd1;
                    end
                end
            end
            ST_CHK_LO: begin
                if (s) begin
                    state_next = ST_HIGH;
                    cnt_next   = 8'd0;
                end else if (cnt == LAST) begin
                    state_next = ST_LOW;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        level_next = (state_next == ST_HIGH) || (state_next == ST_CHK_LO);
        rise       = ((state == ST_CHK_HI) && s && (cnt == LAST)) ||
                     ((DEBOUNCE == 1) && (state == ST_LOW) && s);
    end

endmodule

// File: rtl/edge_event_counter.sv
// Debounced rising-edge detector with a saturating or wrapping event counter
// and a sticky overflow flag.
module edge_event_counter
    import edge_event_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_sig,
    input  logic             enable,
    input  logic             clear,
    output logic             level,
    output logic             pulse,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic rise;

    sig_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .in_sig (in_sig),
        .level  (level),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            pulse <= rise;
            // clear wins over an increment landing on the same edge
            if (clear) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (rise && enable) begin
                if (count == MAX) begin
                    overflow <= 1'b1;
                    if (SATURATE == 0) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule
